frame_reader: RTL and testbench
===============================

Name: frame_reader

Overview:
- Read-side master for the dual-port pixel frame buffer RAM. It scans one frame in raster order through the RAM read port (READ_EN/rd_addr/dout, 1-cycle read latency).
- It presents the pixels as a valid/ready stream with start-of-frame and end-of-line flags, for the display/output path.
- Absorbs RAM read latency and downstream backpressure with a 2-entry output buffer, so no pixel is lost or duplicated.

Parameters:
ADDRESS_WIDTH, 20, width of RAM read address
DATA_WIDTH, 15, pixel width (matches RAM data width)
H_RES, 640, pixels per line
V_RES, 480, lines per frame; H_RES*V_RES must be <= 2**ADDRESS_WIDTH

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle request to scan one frame; ignored while busy=1
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse after the last pixel handshake
READ_EN  out  1  RAM read enable
rd_addr  out  ADDRESS_WIDTH  RAM read address
rd_data  in  DATA_WIDTH  RAM dout; valid the cycle after READ_EN=1
out_data  out  DATA_WIDTH  pixel
out_valid  out  1  out_data/flags valid
out_ready  in  1  downstream accept; transfer when out_valid&&out_ready
out_sof  out  1  high with the first pixel of the frame (address 0)
out_eol  out  1  high with the last pixel of each line (x==H_RES-1)

Behaviour:
- Reset (rst=1 at posedge): state=IDLE; busy, done, READ_EN, out_valid, out_sof, out_eol=0; rd_addr, out_data=0. Buffer emptied, in-flight-read flag cleared, x/y counters=0. Reset mid-frame aborts the frame with no done pulse. RAM data returned in the cycle after reset is discarded.
- FSM states:
  - IDLE: start=1 -> RUN; clear rd_addr, x, y.
  - RUN: issues reads. After the read of address H_RES*V_RES-1 is issued -> DRAIN.
  - DRAIN: no reads. When the buffer is empty and no read is in flight -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
  - busy=1 in RUN, DRAIN and DONE.
- Read issue: READ_EN=1 in RUN only when (buffer occupancy + in-flight read) < 2, evaluated with the same cycle's pop counted. A read issued at cycle t writes the buffer at t+1. rd_addr increments by 1 after each issued read. Address = y*H_RES + x, linear from 0, no gaps.
- Flags are computed at issue from the x/y counters and stored alongside the data:
  - sof = (x==0 && y==0)
  - eol = (x==H_RES-1)
  - x wraps to 0 at H_RES-1, and y increments on that wrap.
- Buffer: 2-entry FIFO of {data, sof, eol}. out_valid = buffer non-empty; outputs come from the head entry. Push and pop in the same cycle are both honoured, occupancy unchanged.
- Pixel order and count: exactly H_RES*V_RES transfers per frame, in address order. out_valid is held with stable data while out_ready=0. Overflow is impossible by credit rule.
- Throughput: with out_ready held at 1, one pixel per cycle after the initial latency.
  - First READ_EN is the cycle after start.
  - First out_valid is 2 cycles after start.
  - done asserts 1 cycle after the last transfer.
- start during busy is ignored. start on the same cycle as done is ignored; it is accepted in IDLE on the next cycle.

Test Plan:
- Bench config: H_RES=4, V_RES=2, ADDRESS_WIDTH=4; RAM model preloaded with mem[i]=i+100.
- start pulse, out_ready=1 -> READ_EN high at cycles 1..8 with rd_addr 0..7; out_valid cycles 2..9 with data 100..107; out_sof only on 100; out_eol on 103 and 107; done at cycle 10, busy low at cycle 11.
- out_ready toggled 1,0,1,0... -> data sequence still 100..107 with no repeats or gaps; out_data stable whenever out_valid=1 and out_ready=0; buffer occupancy never exceeds 2 and READ_EN never asserts while the credit is exhausted.
- out_ready=0 for 20 cycles after start -> exactly 2 reads issued (addr 0,1), out_valid=1 holding 100. Releasing out_ready -> remaining 102..107 follow in order.
- Second start pulse mid-frame -> ignored, only 8 transfers and one done pulse. New start after done -> frame repeats from address 0 with sof.
- rst asserted at the 4th transfer -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent start produces a full frame 100..107.

Source files
------------

// File: rtl/frame_reader_if.sv
// frame_reader_if: bundles the frame reader's control, RAM read port and
// pixel stream signals.
//   start/busy/done        frame scan control
//   READ_EN/rd_addr/rd_data RAM read port (1-cycle read latency)
//   out_* / out_ready      pixel stream with sof/eol flags
// Modports: master = frame reader side, slave = environment side.
interface frame_reader_if #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 15
);
  logic                     start;
  logic                     busy;
  logic                     done;
  logic                     READ_EN;
  logic [ADDRESS_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0]    rd_data;
  logic [DATA_WIDTH-1:0]    out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_sof;
  logic                     out_eol;

  modport master (
    input  start, rd_data, out_ready,
    output busy, done, READ_EN, rd_addr, out_data, out_valid, out_sof, out_eol
  );

  modport slave (
    output start, rd_data, out_ready,
    input  busy, done, READ_EN, rd_addr, out_data, out_valid, out_sof, out_eol
  );
endinterface

// File: rtl/frame_reader.sv
// frame_reader: scans one frame of the pixel buffer RAM in raster order and
// streams it out as valid/ready pixels with start-of-frame / end-of-line
// flags.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - frame_reader_if.master (start/busy/done, RAM read port, pixel
//          stream)
// The 2-entry output buffer counts the read in flight as an entry: the RAM
// word arriving this cycle is presented straight out when nothing older is
// stored, and is written into storage only if it is not consumed at once.
module frame_reader #(
  parameter int ADDRESS_WIDTH = 20,
  parameter int DATA_WIDTH    = 15,
  parameter int H_RES         = 640,
  parameter int V_RES         = 480
) (
  input logic           clk,
  input logic           rst,
  frame_reader_if.master bus
);

  localparam int unsigned TOTAL = H_RES * V_RES;
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;
  } pix_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                   r_state, w_state_nxt;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [XW-1:0]            r_x;
  logic [YW-1:0]            r_y;
  logic                     r_inflight;
  logic                     r_if_sof, r_if_eol;   // flags of the read in flight
  pix_t                     r_fifo [2];
  logic                     r_wp, r_rp;
  logic [1:0]               r_cnt;                // stored entries only

  pix_t       w_head;
  logic       w_valid, w_pop, w_pop_st, w_store, w_issue, w_last;
  logic [1:0] w_occ_after;

  // Head: oldest stored entry, else the word returning from the RAM.
  always_comb begin
    w_head = '0;
    if (r_cnt != 2'd0)
      w_head = r_fifo[r_rp];
    else if (r_inflight)
      w_head = '{data: bus.rd_data, sof: r_if_sof, eol: r_if_eol};
  end

  assign w_valid     = (r_cnt != 2'd0) || r_inflight;
  assign w_pop       = w_valid && bus.out_ready;
  assign w_pop_st    = w_pop && (r_cnt != 2'd0);
  // Returning word is stored unless it is consumed in the cycle it arrives.
  assign w_store     = r_inflight && !(w_pop && (r_cnt == 2'd0));
  // Credit seen by the issue logic: stored + in flight, less this cycle's pop.
  assign w_occ_after = r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
  assign w_issue     = (r_state == S_RUN) && (w_occ_after < 2'd2);
  assign w_last      = (r_addr == ADDRESS_WIDTH'(TOTAL - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_issue && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_occ_after == 2'd0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_inflight <= 1'b0;
      r_if_sof   <= 1'b0;
      r_if_eol   <= 1'b0;
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;

      if (r_state == S_IDLE && bus.start) begin
        r_addr <= '0;
        r_x    <= '0;
        r_y    <= '0;
      end else if (w_issue) begin
        r_addr   <= r_addr + 1'b1;
        r_if_sof <= (r_x == '0) && (r_y == '0);
        r_if_eol <= (r_x == XW'(H_RES - 1));
        if (r_x == XW'(H_RES - 1)) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end

      if (w_store) begin
        r_fifo[r_wp] <= '{data: bus.rd_data, sof: r_if_sof, eol: r_if_eol};
        r_wp         <= ~r_wp;
      end
      if (w_pop_st) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_store} - {1'b0, w_pop_st};
    end
  end

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.READ_EN   = w_issue;
  assign bus.rd_addr   = r_addr;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_head.data;
  assign bus.out_sof   = w_head.sof;
  assign bus.out_eol   = w_head.eol;

endmodule

// File: tb/tb_frame_reader.sv
// tb_frame_reader: scoreboard bench for frame_reader on a 4x2 frame with a
// 1-cycle-latency RAM model holding mem[i] = i + 100.
module tb_frame_reader;
  localparam int AW = 4;
  localparam int DW = 15;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = H * V;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
  } pix_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_reader_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus();
  frame_reader #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .H_RES(H), .V_RES(V))
    dut (.clk(clk), .rst(rst), .bus(bus));

  logic [DW-1:0] mem [16];
  always @(posedge clk) if (bus.READ_EN) bus.rd_data <= mem[bus.rd_addr];

  wire [24:0] w_outs = {bus.busy, bus.done, bus.READ_EN, bus.rd_addr,
                        bus.out_valid, bus.out_data, bus.out_sof, bus.out_eol};

  int   n_run = 0, n_fail = 0;
  int   cyc = 0, t0 = 0;
  int   exp_addr = 0, n_rd = 0, n_xf = 0, n_done = 0, occ = 0;
  bit   timing = 0, hold = 0, pop = 0;
  logic [DW-1:0] hold_d;
  pix_t exp_q[$];
  pix_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic start_frame;
    pix_t p;
    exp_addr = 0; n_rd = 0; n_xf = 0;
    for (int i = 0; i < N; i++) begin
      p.d   = DW'(i + 100);
      p.sof = (i == 0);
      p.eol = ((i % H) == H - 1);
      exp_q.push_back(p);
    end
    bus.start = 1'b1;
    t0 = cyc;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (n_done >= target) break;
      tick();
    end
    chk("done_timeout", 32'(n_done >= target), 1);
  endtask

  task automatic frame_counts(input string tag);
    chk({tag, "_reads"}, n_rd, N);
    chk({tag, "_xfers"}, n_xf, N);
    chk({tag, "_q_empty"}, exp_q.size(), 0);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      pop = bus.out_valid && bus.out_ready;
      if (hold) begin
        chk("hold_vld", bus.out_valid, 1);
        chk("hold_data", bus.out_data, hold_d);
      end
      hold   = bus.out_valid && !bus.out_ready;
      hold_d = bus.out_data;
      if (bus.READ_EN) begin
        chk("rd_addr", bus.rd_addr, exp_addr);
        if (timing) chk("rd_cyc", cyc - t0, exp_addr + 1);
        chk("credit", 32'((occ - int'(pop)) < 2), 1);
        exp_addr++;
        n_rd++;
      end
      if (pop) begin
        if (exp_q.size() == 0) chk("extra_pix", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("pix", {bus.out_data, bus.out_sof, bus.out_eol}, e);
          if (timing) chk("out_cyc", cyc - t0, n_xf + 2);
        end
        n_xf++;
      end
      occ = occ + int'(bus.READ_EN) - int'(pop);
      if (bus.done) begin
        n_done++;
        if (timing) chk("done_cyc", cyc - t0, N + 2);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected done", n_done);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 100);
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_outs", w_outs, 0);
    rst = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);

    // Full-rate frame with exact cycle checks.
    timing = 1;
    start_frame();
    wait_done(1, 40);
    timing = 0;
    chk("idle_cyc", cyc - t0, N + 3);
    chk("busy_low", bus.busy, 0);
    frame_counts("f1");

    // Alternating backpressure.
    start_frame();
    for (int i = 0; i < 100 && n_done < 2; i++) begin
      bus.out_ready = ~bus.out_ready;
      tick();
    end
    chk("toggle_done", n_done, 2);
    bus.out_ready = 1'b1;
    tick();
    frame_counts("f2");

    // Long stall right after start.
    bus.out_ready = 1'b0;
    start_frame();
    repeat (20) tick();
    chk("bp_reads", n_rd, 2);
    chk("bp_xfers", n_xf, 0);
    chk("bp_vld", bus.out_valid, 1);
    chk("bp_data", bus.out_data, 100);
    bus.out_ready = 1'b1;
    wait_done(3, 40);
    frame_counts("f3");

    // Start mid-frame and start coincident with done are both ignored.
    start_frame();
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 40 && !bus.done; i++) tick();
    chk("done_seen", bus.done, 1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_on_done", bus.busy, 0);
    repeat (3) tick();
    chk("one_done", n_done, 4);
    chk("still_idle", bus.busy, 0);
    frame_counts("f4");

    // Reset at the 4th transfer aborts the frame silently.
    start_frame();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_outs", w_outs, 0);
    chk("rst_mid_xfers", n_xf, 4);
    rst = 1'b0;
    exp_q.delete();
    occ  = 0;
    hold = 0;
    repeat (5) tick();
    chk("no_done_after_rst", n_done, 4);
    chk("rst_idle", bus.busy, 0);

    start_frame();
    wait_done(5, 40);
    frame_counts("f5");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
